ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core.
- Captures decoded operands and controls from ID, resolves EX/MEM and MEM/WB forwarding, and drives SrcA/SrcB/Operation of the EX-stage ALU.
- Detects load-use hazards, issues the ID/IF stall, and inserts a bubble. Branch/jump flush clears the stage.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  branch/jump taken; kill instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_WIDTH  source indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  REG_ADDR_WIDTH  destination index
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_pc  in  DATA_WIDTH  instruction PC
- id_a_sel  in  2  SrcA select: 0 rs1, 1 pc, 2 zero, 3 reserved (zero)
- id_b_imm  in  1  SrcB select: 0 rs2, 1 imm
- id_operation  in  OPCODE_LENGTH  ALU operation code
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- exmem_rd  in  REG_ADDR_WIDTH; exmem_reg_write  in  1; exmem_result  in  DATA_WIDTH  (stage after EX)
- memwb_rd  in  REG_ADDR_WIDTH; memwb_reg_write  in  1; memwb_result  in  DATA_WIDTH  (writeback value)
- id_stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- src_a, src_b  out  DATA_WIDTH  ALU operands
- operation  out  OPCODE_LENGTH  ALU operation
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value, used for stores
- ex_rd  out  REG_ADDR_WIDTH; ex_pc, ex_imm  out  DATA_WIDTH; ex_reg_write, ex_mem_read, ex_mem_write  out  1

Behaviour:
- Clocking and reset: one clock (clk). reset is synchronous and active-high. On reset all EX registers go to 0, so ex_valid=0, all controls=0, operation=0, ex_rd=0, and src_a/src_b/ex_store_data=0. id_stall=0 during and after reset until a hazard is present.
- Register update priority each edge: reset > flush > load-use bubble > capture.
  - flush=1: EX becomes a bubble (valid and all controls 0). Stall is ignored.
  - bubble: same clear as flush. ID is not consumed; upstream holds it.
  - capture: all id_* fields are latched. ex_valid=id_valid. Controls are ANDed with id_valid.
- Latency: one cycle from id_* to ex_* / operands.
- Load-use hazard (combinational): id_stall=1 iff all of the following hold:
  - ex_valid & ex_mem_read & ex_rd!=0
  - ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
  - id_valid & !flush
  - Exactly one bubble per load-use. On the next cycle the load is in EX/MEM and forwarding from MEM/WB resolves the operand.
- Forwarding (combinational on registered ex_rs1/ex_rs2):
  - EX/MEM match wins: exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rsN.
  - Else MEM/WB match: memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rsN.
  - Else the registered register-file data.
  - Index 0 is never forwarded; its value is always the registered data (0).
- Operand muxing:
  - src_a per registered a_sel using forwarded rs1; reserved select gives 0.
  - src_b = imm if b_imm, else forwarded rs2.
  - ex_store_data is always forwarded rs2, independent of b_imm.
- operation passes through registered; a bubble presents operation=0 with zeroed operands.
- Same-cycle regfile write/read hazards in ID are owned by the register file, not this block.
- Bubble outputs remain well-defined (no X) for the ALU.

Decomposition:
- Shared package core_pkg holds:
  - ALU operation constants (ALU_AND=0, ALU_OR=1, ALU_XOR=2, ALU_ADD=3, ALU_SUB=4, ALU_SRL=5, ALU_SRA=6, ALU_SLL=7, ALU_BEQ=8, ALU_BNE=9, ALU_SLT=10, ALU_BGE=11, ALU_JALR=12, ALU_LUI=13, ALU_SLTU=14, ALU_BGEU=15)
  - the a_sel enum (ASEL_RS1, ASEL_PC, ASEL_ZERO)
  - a packed struct for the ID/EX control bundle
- One sub-module: forward_select, a pure combinational rsN value/index vs exmem/memwb priority mux, instantiated twice.

Test Plan:
- Reset with id_valid=1 held -> after reset edge ex_valid=0, src_a=src_b=0, operation=0, id_stall=0.
- ADDI x1,x0,5 (a_sel=0, b_imm=1, imm=5, rs1_data=0) -> next cycle src_a=0, src_b=5, operation=3, ex_rd=1, ex_reg_write=1.
- EX-operand rs1=2 with exmem_rd=2 result 0x11 and memwb_rd=2 result 0x22 -> src_a=0x11. Drop exmem_reg_write -> src_a=0x22. Set rs1=0 with both matching rd=0 -> src_a=registered 0.
- LW x5 in EX, ID instruction uses rs2=5 -> id_stall=1 for exactly one cycle, next EX ex_valid=0. The following cycle the instruction is captured, and with memwb_rd=5 result 0xDEADBEEF, src_b=0xDEADBEEF.
- flush=1 concurrent with a load-use stall condition -> id_stall=0, next cycle ex_valid=0 and all controls 0.
- SW with b_imm=1, imm=8, rs2=3, exmem_rd=3 result 0x1234 -> src_b=8, ex_store_data=0x1234, ex_mem_write=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: ALU operation codes, SrcA select encoding
// and the ID/EX control bundle carried by the operand stage.
package core_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_BEQ  = 4'd8;
    localparam logic [3:0] ALU_BNE  = 4'd9;
    localparam logic [3:0] ALU_SLT  = 4'd10;
    localparam logic [3:0] ALU_BGE  = 4'd11;
    localparam logic [3:0] ALU_JALR = 4'd12;
    localparam logic [3:0] ALU_LUI  = 4'd13;
    localparam logic [3:0] ALU_SLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

    // Encoding 2'd3 is reserved and behaves as ASEL_ZERO.
    typedef enum logic [1:0] {
        ASEL_RS1  = 2'd0,
        ASEL_PC   = 2'd1,
        ASEL_ZERO = 2'd2
    } a_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       b_imm;
        logic [1:0] a_sel;
    } idex_ctrl_t;

endpackage

// File: rtl/forward_select.sv
// Operand bypass mux: EX/MEM result beats MEM/WB result beats register-file data.
// Register x0 never matches because a producer with rd=0 is ignored.
module forward_select #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0]     rs_data,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic                      memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     value
);

    // Priority select of the freshest producer of rs
    always_comb begin
        value = rs_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
            value = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
            value = memwb_result;
        end else begin
            value = rs_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall/bubble
// insertion and branch flush, feeding SrcA/SrcB/operation to the EX ALU.
module ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [1:0]                id_a_sel,
    input  logic                      id_b_imm,
    input  logic [OPCODE_LENGTH-1:0]  id_operation,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic                      memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic                      id_stall,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     src_a,
    output logic [DATA_WIDTH-1:0]     src_b,
    output logic [OPCODE_LENGTH-1:0]  operation,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write
);

    import core_pkg::*;

    idex_ctrl_t                ctrl_r;
    idex_ctrl_t                id_ctrl_s;
    logic                      ex_valid_r;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1_r;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2_r;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_r;
    logic [DATA_WIDTH-1:0]     rs1_data_r;
    logic [DATA_WIDTH-1:0]     rs2_data_r;
    logic [DATA_WIDTH-1:0]     imm_r;
    logic [DATA_WIDTH-1:0]     pc_r;
    logic [OPCODE_LENGTH-1:0]  op_r;
    logic                      load_use_s;
    logic [DATA_WIDTH-1:0]     rs1_fwd_s;
    logic [DATA_WIDTH-1:0]     rs2_fwd_s;
    logic [DATA_WIDTH-1:0]     src_a_s;

    // Side-effecting controls only survive for a real instruction
    always_comb begin
        id_ctrl_s           = '0;
        id_ctrl_s.reg_write = id_reg_write & id_valid;
        id_ctrl_s.mem_read  = id_mem_read  & id_valid;
        id_ctrl_s.mem_write = id_mem_write & id_valid;
        id_ctrl_s.b_imm     = id_b_imm;
        id_ctrl_s.a_sel     = id_a_sel;
    end

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use_s = 1'b0;
        if (ex_valid_r && ctrl_r.mem_read && (ex_rd_r != '0) && id_valid && !flush) begin
            load_use_s = (id_use_rs1 && (id_rs1 == ex_rd_r)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd_r));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Stage register; flush and bubble clear everything so the ALU sees zeros
    always_ff @(posedge clk) begin
        if (reset || flush || load_use_s) begin
            ex_valid_r <= 1'b0;
            ctrl_r     <= '0;
            ex_rs1_r   <= '0;
            ex_rs2_r   <= '0;
            ex_rd_r    <= '0;
            rs1_data_r <= '0;
            rs2_data_r <= '0;
            imm_r      <= '0;
            pc_r       <= '0;
            op_r       <= '0;
        end else begin
            ex_valid_r <= id_valid;
            ctrl_r     <= id_ctrl_s;
            ex_rs1_r   <= id_rs1;
            ex_rs2_r   <= id_rs2;
            ex_rd_r    <= id_rd;
            rs1_data_r <= id_rs1_data;
            rs2_data_r <= id_rs2_data;
            imm_r      <= id_imm;
            pc_r       <= id_pc;
            op_r       <= id_operation;
        end
    end

    forward_select #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .rs              (ex_rs1_r),
        .rs_data         (rs1_data_r),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .value           (rs1_fwd_s)
    );

    forward_select #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .rs              (ex_rs2_r),
        .rs_data         (rs2_data_r),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .value           (rs2_fwd_s)
    );

    // SrcA select; the reserved encoding reads as zero
    always_comb begin
        src_a_s = '0;
        case (ctrl_r.a_sel)
            ASEL_RS1:  src_a_s = rs1_fwd_s;
            ASEL_PC:   src_a_s = pc_r;
            ASEL_ZERO: src_a_s = '0;
            default:   src_a_s = '0;
        endcase
    end

    assign id_stall      = load_use_s;
    assign ex_valid      = ex_valid_r;
    assign src_a         = src_a_s;
    assign src_b         = ctrl_r.b_imm ? imm_r : rs2_fwd_s;
    assign operation     = op_r;
    assign ex_store_data = rs2_fwd_s;
    assign ex_rd         = ex_rd_r;
    assign ex_pc         = pc_r;
    assign ex_imm        = imm_r;
    assign ex_reg_write  = ctrl_r.reg_write;
    assign ex_mem_read   = ctrl_r.mem_read;
    assign ex_mem_write  = ctrl_r.mem_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, capture, forwarding priority,
// load-use bubble, flush over stall and store-data forwarding.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset, flush, id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [1:0]  id_a_sel;
    logic        id_b_imm;
    logic [3:0]  id_operation;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        id_stall, ex_valid;
    logic [31:0] src_a, src_b, ex_store_data, ex_pc, ex_imm;
    logic [3:0]  operation;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_a_sel(id_a_sel), .id_b_imm(id_b_imm),
        .id_operation(id_operation), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .id_stall(id_stall), .ex_valid(ex_valid), .src_a(src_a), .src_b(src_b),
        .operation(operation), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0; id_pc = 32'd0;
        id_a_sel = 2'd0; id_b_imm = 1'b0; id_operation = 4'd0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    endtask

    initial begin
        flush = 1'b0;
        clear_id();
        exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_result = 32'd0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 32'd0;

        // Reset with a live instruction presented in ID
        reset = 1'b1;
        id_valid = 1'b1; id_rd = 5'd9; id_imm = 32'h77; id_b_imm = 1'b1;
        id_operation = 4'd3; id_reg_write = 1'b1;
        tick();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_src_a", src_a, 32'd0);
        chk("rst_src_b", src_b, 32'd0);
        chk("rst_op", 32'(operation), 32'd0);
        chk("rst_stall", 32'(id_stall), 32'd0);
        chk("rst_regwr", 32'(ex_reg_write), 32'd0);

        // ADDI x1, x0, 5
        reset = 1'b0;
        clear_id();
        id_valid = 1'b1; id_use_rs1 = 1'b1; id_imm = 32'd5; id_b_imm = 1'b1;
        id_operation = 4'd3; id_rd = 5'd1; id_reg_write = 1'b1;
        tick();
        chk("addi_src_a", src_a, 32'd0);
        chk("addi_src_b", src_b, 32'd5);
        chk("addi_op", 32'(operation), 32'd3);
        chk("addi_rd", 32'(ex_rd), 32'd1);
        chk("addi_regwr", 32'(ex_reg_write), 32'd1);
        chk("addi_valid", 32'(ex_valid), 32'd1);

        // Forwarding priority on rs1=2
        clear_id();
        id_valid = 1'b1; id_rs1 = 5'd2; id_use_rs1 = 1'b1; id_rs1_data = 32'h99;
        id_operation = 4'd3; id_rd = 5'd3; id_reg_write = 1'b1;
        tick();
        exmem_rd = 5'd2; exmem_reg_write = 1'b1; exmem_result = 32'h11;
        memwb_rd = 5'd2; memwb_reg_write = 1'b1; memwb_result = 32'h22;
        #1 chk("fwd_exmem", src_a, 32'h11);
        exmem_reg_write = 1'b0;
        #1 chk("fwd_memwb", src_a, 32'h22);
        memwb_reg_write = 1'b0;
        #1 chk("fwd_none", src_a, 32'h99);

        // x0 is never forwarded
        clear_id();
        id_valid = 1'b1; id_use_rs1 = 1'b1; id_operation = 4'd3;
        id_pc = 32'h400;
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'h11;
        memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'h22;
        tick();
        chk("fwd_x0", src_a, 32'd0);

        // SrcA = PC, then reserved select gives zero
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
        clear_id();
        id_valid = 1'b1; id_a_sel = 2'd1; id_pc = 32'h1000; id_rs1 = 5'd4;
        id_rs1_data = 32'h44; id_operation = 4'd3;
        tick();
        chk("asel_pc", src_a, 32'h1000);
        id_a_sel = 2'd3;
        tick();
        chk("asel_rsvd", src_a, 32'd0);

        // LW x5 enters EX
        clear_id();
        id_valid = 1'b1; id_b_imm = 1'b1; id_imm = 32'd0; id_operation = 4'd3;
        id_rd = 5'd5; id_reg_write = 1'b1; id_mem_read = 1'b1;
        tick();
        chk("lw_memrd", 32'(ex_mem_read), 32'd1);
        // Dependent ADD x6, x0, x5
        clear_id();
        id_valid = 1'b1; id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_rs2_data = 32'h55;
        id_operation = 4'd3; id_rd = 5'd6; id_reg_write = 1'b1;
        #1 chk("lu_stall", 32'(id_stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_regwr", 32'(ex_reg_write), 32'd0);
        chk("lu_bubble_op", 32'(operation), 32'd0);
        chk("lu_bubble_src_b", src_b, 32'd0);
        chk("lu_stall_once", 32'(id_stall), 32'd0);
        memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'hDEADBEEF;
        tick();
        chk("lu_capture_valid", 32'(ex_valid), 32'd1);
        chk("lu_capture_rd", 32'(ex_rd), 32'd6);
        chk("lu_fwd_src_b", src_b, 32'hDEADBEEF);
        memwb_reg_write = 1'b0;

        // Flush concurrent with a load-use condition
        clear_id();
        id_valid = 1'b1; id_b_imm = 1'b1; id_operation = 4'd3;
        id_rd = 5'd7; id_reg_write = 1'b1; id_mem_read = 1'b1;
        tick();
        clear_id();
        id_valid = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1; id_operation = 4'd4;
        id_rd = 5'd8; id_reg_write = 1'b1; id_mem_write = 1'b1;
        #1 chk("fl_pre_stall", 32'(id_stall), 32'd1);
        flush = 1'b1;
        #1 chk("fl_stall", 32'(id_stall), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_regwr", 32'(ex_reg_write), 32'd0);
        chk("fl_memrd", 32'(ex_mem_read), 32'd0);
        chk("fl_memwr", 32'(ex_mem_write), 32'd0);
        chk("fl_op", 32'(operation), 32'd0);

        // SW: src_b is the offset, store data is forwarded rs2
        clear_id();
        id_valid = 1'b1; id_b_imm = 1'b1; id_imm = 32'd8; id_rs2 = 5'd3;
        id_use_rs2 = 1'b1; id_use_rs1 = 1'b1; id_rs2_data = 32'h777;
        id_operation = 4'd3; id_mem_write = 1'b1;
        exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'h1234;
        tick();
        chk("sw_src_b", src_b, 32'd8);
        chk("sw_store", ex_store_data, 32'h1234);
        chk("sw_memwr", 32'(ex_mem_write), 32'd1);
        chk("sw_imm", ex_imm, 32'd8);

        // Invalid instruction: controls masked
        exmem_reg_write = 1'b0;
        id_valid = 1'b0; id_reg_write = 1'b1; id_mem_write = 1'b1;
        tick();
        chk("inv_valid", 32'(ex_valid), 32'd0);
        chk("inv_regwr", 32'(ex_reg_write), 32'd0);
        chk("inv_memwr", 32'(ex_mem_write), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
